// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetches instruction words over a wait-state bus into a two-entry FIFO
// and presents the head to the scheduler; stops accepting addresses after the halt address.
module instr_fetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_addr_valid,
  output logic        fetch_addr_ready,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_readdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_addr,
  input  logic        stall,
  output logic        active
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        active_q, active_d, run_q, run_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] dat_q [DEPTH], dat_d [DEPTH], pc_q [DEPTH], pc_d [DEPTH];
  logic        push, pop, accept;
  // run_q keeps ready low until the first edge after reset is released
  assign fetch_addr_ready = run_q && clk_enable && active_q && state_q == IDLE && cnt_q != 2'(DEPTH);
  assign instr_read       = state_q == REQ;
  assign instr_address    = addr_q;
  assign instr_valid      = cnt_q != 2'd0;
  assign instr_data       = dat_q[0];
  assign instr_addr       = pc_q[0];
  assign active           = active_q;
  always_comb begin
    pop      = cnt_q != 2'd0 && !stall && clk_enable;
    push     = state_q == REQ && !instr_waitrequest;
    accept   = fetch_addr_valid && fetch_addr_ready;
    state_d  = state_q;
    addr_d   = addr_q;
    active_d = active_q;
    run_d    = 1'b1;
    dat_d    = dat_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q - {1'b0, pop};
    if (pop) begin
      dat_d[0] = dat_q[1];
      pc_d[0]  = pc_q[1];
      dat_d[1] = '0;
      pc_d[1]  = '0;
    end
    if (push) begin
      dat_d[cnt_d[0]] = instr_readdata;
      pc_d[cnt_d[0]]  = addr_q;
      cnt_d           = cnt_d + 2'd1;
      state_d         = IDLE;
    end
    if (accept && fetch_addr == HALT_ADDR) active_d = 1'b0;
    if (accept && fetch_addr != HALT_ADDR) begin
      addr_d  = fetch_addr;
      state_d = REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      active_q <= 1'b1;
      run_q    <= 1'b0;
      cnt_q    <= '0;
      dat_q    <= '{default: '0};
      pc_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      active_q <= active_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      pc_q     <= pc_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (a queue of fetched words plus one pending read).
module tb_instr_fetch_buffer;
  logic        clk = 1'b0, reset = 1'b0, clk_enable = 1'b1;
  logic [31:0] fetch_addr = '0, instr_readdata = '0;
  logic        fetch_addr_valid = 1'b0, instr_waitrequest = 1'b0, stall = 1'b0;
  logic        fetch_addr_ready, instr_read, instr_valid, active;
  logic [31:0] instr_address, instr_data, instr_addr;
  int          errors = 0, checks = 0;
  logic [63:0] mq [$];
  logic        m_pend = 1'b0, m_active = 1'b1, m_run = 1'b0;
  logic [31:0] m_addr = '0;

  instr_fetch_buffer dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .fetch_addr(fetch_addr), .fetch_addr_valid(fetch_addr_valid), .fetch_addr_ready(fetch_addr_ready),
    .instr_address(instr_address), .instr_read(instr_read),
    .instr_waitrequest(instr_waitrequest), .instr_readdata(instr_readdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
    .stall(stall), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic rdy, do_pop, do_push;
    @(negedge clk);
    rdy = m_run && clk_enable && m_active && !m_pend && mq.size() < 2;
    chk("ready", {31'b0, fetch_addr_ready}, {31'b0, rdy});
    chk("read", {31'b0, instr_read}, {31'b0, m_pend});
    chk("address", instr_address, m_addr);
    chk("valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
    chk("data", instr_data, mq.size() != 0 ? mq[0][31:0] : 32'h0);
    chk("iaddr", instr_addr, mq.size() != 0 ? mq[0][63:32] : 32'h0);
    chk("active", {31'b0, active}, {31'b0, m_active});
    if (!reset) begin
      mq.delete();
      m_pend = 1'b0; m_addr = '0; m_active = 1'b1; m_run = 1'b0;
    end else begin
      do_pop  = mq.size() != 0 && !stall && clk_enable;
      do_push = m_pend && !instr_waitrequest;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        chk("no_overflow", {31'b0, mq.size() < 2}, 32'd1);
        mq.push_back({m_addr, instr_readdata});
        m_pend = 1'b0;
      end
      if (rdy && fetch_addr_valid) begin
        if (fetch_addr == 32'h0) m_active = 1'b0;
        else begin m_pend = 1'b1; m_addr = fetch_addr; end
      end
      m_run = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_addr = a; fetch_addr_valid = 1'b1;
    cyc();
    fetch_addr_valid = 1'b0;
  endtask

  initial begin
    fetch_addr_valid = 1'b1; fetch_addr = 32'hBFC0_0000;
    cyc(); cyc();
    reset = 1'b1; fetch_addr_valid = 1'b0;
    cyc();
    // zero-wait fetch
    instr_readdata = 32'h2402_0005;
    fetch(32'hBFC0_0000);
    repeat (3) cyc();
    // three wait states
    instr_waitrequest = 1'b1; instr_readdata = 32'h2403_0007;
    fetch(32'hBFC0_0004);
    repeat (3) cyc();
    instr_waitrequest = 1'b0;
    repeat (3) cyc();
    // backpressure fills both entries
    stall = 1'b1;
    instr_readdata = 32'h1111_1111; fetch(32'hBFC0_0000); cyc();
    instr_readdata = 32'h2222_2222; fetch(32'hBFC0_0004); cyc();
    fetch_addr_valid = 1'b1; fetch_addr = 32'hBFC0_0008;
    cyc(); cyc();
    chk("full_not_ready", {31'b0, fetch_addr_ready}, 32'd0);
    fetch_addr_valid = 1'b0; stall = 1'b0;
    repeat (3) cyc();
    // halt with one word buffered
    stall = 1'b1; instr_readdata = 32'h3333_3333;
    fetch(32'hBFC0_0008); cyc();
    fetch(32'h0);
    fetch_addr_valid = 1'b1; fetch_addr = 32'hBFC0_000C;
    cyc(); cyc();
    chk("halted_active", {31'b0, active}, 32'd0);
    chk("halted_ready", {31'b0, fetch_addr_ready}, 32'd0);
    fetch_addr_valid = 1'b0; stall = 1'b0;
    cyc(); cyc();
    // reset during a stalled transfer
    reset = 1'b0; cyc(); reset = 1'b1; cyc();
    instr_waitrequest = 1'b1;
    fetch(32'hBFC0_0010); cyc();
    reset = 1'b0; cyc();
    reset = 1'b1; instr_waitrequest = 1'b0;
    cyc(); cyc();
    chk("no_push_after_reset", {31'b0, instr_valid}, 32'd0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset             = $urandom_range(0, 149) != 0;
      clk_enable        = $urandom_range(0, 7) != 0;
      fetch_addr_valid  = $urandom_range(0, 1) == 1;
      fetch_addr        = $urandom_range(0, 59) == 0 ? 32'h0 : {$urandom_range(1, 32'h3FFF_FFFF), 2'b00};
      instr_waitrequest = $urandom_range(0, 2) == 0;
      instr_readdata    = $urandom;
      stall             = $urandom_range(0, 2) == 0;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
